// File: rtl/sd_arbiter.sv
// Two-port round-robin arbiter in front of one sd_controller2 block-transfer port.
// Drives the controller's hold-until-busy enable handshake and returns ack/err pulses per port.
module sd_arbiter #(
    parameter int DataSize     = 4096,
    parameter int AddrSize     = 32,
    parameter int StartTimeout = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rd_en0,
    input  logic                wr_en0,
    input  logic [AddrSize-1:0] addr0,
    input  logic [DataSize-1:0] write_data0,
    output logic                ack0,
    output logic                err0,
    input  logic                rd_en1,
    input  logic                wr_en1,
    input  logic [AddrSize-1:0] addr1,
    input  logic [DataSize-1:0] write_data1,
    output logic                ack1,
    output logic                err1,
    output logic [DataSize-1:0] read_data,
    output logic                sd_rd_en,
    output logic                sd_wr_en,
    output logic [AddrSize-1:0] sd_addr,
    output logic [DataSize-1:0] sd_write_data,
    input  logic [DataSize-1:0] sd_read_data,
    input  logic                sd_busy,
    output logic [2:0]          state_dbg
);

    localparam int CW = $clog2(StartTimeout + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BUSY  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          last_grant;

    logic req0, req1, pick1;

    // Requester handshake: a port holds rd_en/wr_en high until its one-cycle ack,
    // then drops it the following cycle; an enable still high in IDLE is a new request.
    // A port with both enables high is served as a read.
    always_comb begin
        req0  = rd_en0 | wr_en0;
        req1  = rd_en1 | wr_en1;
        pick1 = req1 & (~req0 | ~last_grant);
    end

    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            sd_rd_en      <= 1'b0;
            sd_wr_en      <= 1'b0;
            sd_addr       <= '0;
            sd_write_data <= '0;
            read_data     <= '0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sd_busy && (req0 || req1)) begin
                        grant <= pick1;
                        cnt   <= '0;
                        state <= ISSUE;
                        if (pick1) begin
                            sd_addr       <= addr1;
                            sd_write_data <= write_data1;
                            sd_rd_en      <= rd_en1;
                            sd_wr_en      <= ~rd_en1;
                        end else begin
                            sd_addr       <= addr0;
                            sd_write_data <= write_data0;
                            sd_rd_en      <= rd_en0;
                            sd_wr_en      <= ~rd_en0;
                        end
                    end
                end
                ISSUE: begin
                    if (sd_busy) begin
                        cnt   <= '0;
                        state <= BUSY;
                    end else if (cnt == CW'(StartTimeout - 1)) begin
                        // Controller never accepted the command: give up and flag it.
                        sd_rd_en   <= 1'b0;
                        sd_wr_en   <= 1'b0;
                        ack0       <= ~grant;
                        ack1       <= grant;
                        err0       <= ~grant;
                        err1       <= grant;
                        last_grant <= grant;
                        state      <= ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (!sd_busy) begin
                        if (sd_rd_en) read_data <= sd_read_data;
                        sd_rd_en   <= 1'b0;
                        sd_wr_en   <= 1'b0;
                        ack0       <= ~grant;
                        ack1       <= grant;
                        last_grant <= grant;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_arbiter.sv
// Randomized bench for sd_arbiter: behavioural SD-controller stand-in plus a
// transaction-level model of grant order and read_data.
module tb_sd_arbiter;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int TO = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          rd_en0, wr_en0, rd_en1, wr_en1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] write_data0, write_data1;
    logic          ack0, err0, ack1, err1;
    logic [DW-1:0] read_data;
    logic          sd_rd_en, sd_wr_en;
    logic [AW-1:0] sd_addr;
    logic [DW-1:0] sd_write_data;
    logic [DW-1:0] sd_read_data;
    logic          sd_busy;
    logic [2:0]    state_dbg;

    sd_arbiter #(.DataSize(DW), .AddrSize(AW), .StartTimeout(TO)) dut (
        .clock(clock), .reset(reset),
        .rd_en0(rd_en0), .wr_en0(wr_en0), .addr0(addr0), .write_data0(write_data0),
        .ack0(ack0), .err0(err0),
        .rd_en1(rd_en1), .wr_en1(wr_en1), .addr1(addr1), .write_data1(write_data1),
        .ack1(ack1), .err1(err1),
        .read_data(read_data),
        .sd_rd_en(sd_rd_en), .sd_wr_en(sd_wr_en), .sd_addr(sd_addr),
        .sd_write_data(sd_write_data), .sd_read_data(sd_read_data),
        .sd_busy(sd_busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    int            proto_viol = 0;
    logic [DW-1:0] exp_q[$];
    int            m_last;
    logic [DW-1:0] m_read_data;

    always @(negedge clock) begin
        if (reset) begin
            if (sd_rd_en && sd_wr_en) proto_viol++;
            if (ack0 && ack1) proto_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Winner for the current request set: lone requester, else the port not served last.
    function automatic int predict(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        return (m_last == 1) ? 0 : 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_inputs();
        addr0       = $urandom;
        addr1       = $urandom;
        write_data0 = {$urandom, $urandom};
        write_data1 = {$urandom, $urandom};
    endtask

    // Acts as the controller for one transfer and checks it end to end.
    task automatic run_txn(input int p, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input bit rd, input bit no_busy, input int busy_len);
        int            n;
        int            bad;
        int            len;
        logic [DW-1:0] blk;
        logic [DW-1:0] got_wr;
        logic [DW-1:0] exp_rd;
        n = 0;
        while (!(sd_rd_en || sd_wr_en) && n < 300) begin
            tick();
            n++;
        end
        check("grant_wait", 64'(n < 300), 1);
        check("sd_rd_en", sd_rd_en, rd);
        check("sd_wr_en", sd_wr_en, !rd);
        check("sd_addr", sd_addr, a);
        if (no_busy) begin
            exp_q.push_back(m_read_data);
            n = 0;
            while (!(ack0 || ack1) && n < 200) begin
                tick();
                n++;
            end
            check("timeout_cycles", n, TO);
        end else begin
            repeat ($urandom_range(1, 5)) tick();
            sd_busy = 1'b1;
            tick();
            got_wr = sd_write_data;
            len = (busy_len == 0) ? $urandom_range(2, 12) : busy_len;
            bad = 0;
            repeat (len) begin
                tick();
                if (sd_rd_en !== rd || sd_wr_en !== !rd || sd_addr !== a) bad++;
                if (!rd && sd_write_data !== wd) bad++;
                if (ack0 || ack1) bad++;
            end
            check("held_in_busy", bad, 0);
            if (!rd) check("wr_block", got_wr, wd);
            blk = {$urandom, $urandom};
            sd_read_data = blk;
            sd_busy = 1'b0;
            exp_q.push_back(rd ? blk : m_read_data);
            tick();
        end
        exp_rd = exp_q.pop_front();
        check("ack0", ack0, p == 0);
        check("ack1", ack1, p == 1);
        check("err0", err0, no_busy && p == 0);
        check("err1", err1, no_busy && p == 1);
        check("en_drop", {sd_rd_en, sd_wr_en}, 0);
        check("read_data", read_data, exp_rd);
        m_last      = p;
        m_read_data = exp_rd;
        tick();
        check("ack_pulse", {ack0, ack1, err0, err1}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            bad;
        int            n;
        int            p;
        int            op0, op1;
        bit            r0, r1, rd, nb;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;

        reset = 1'b0;
        sd_busy = 1'b1;
        rd_en0 = 0; wr_en0 = 0; rd_en1 = 0; wr_en1 = 0;
        addr0 = '0; addr1 = '0; write_data0 = '0; write_data1 = '0;
        sd_read_data = '0;
        m_last = 1;
        m_read_data = '0;
        repeat (3) tick();
        check("rst_en", {sd_rd_en, sd_wr_en}, 0);
        check("rst_addr", sd_addr, 0);
        check("rst_wdata", sd_write_data, 0);
        check("rst_rdata", read_data, 0);
        check("rst_acks", {ack0, ack1, err0, err1}, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;

        // Card initialisation: busy high must hold off the request.
        rd_en0 = 1'b1;
        addr0  = 32'h0000_1234;
        bad = 0;
        repeat (200) begin
            tick();
            if (sd_rd_en || sd_wr_en) bad++;
        end
        check("init_hold", bad, 0);
        sd_busy = 1'b0;
        tick();
        check("init_release", sd_rd_en, 1);
        run_txn(predict(1, 0), 32'h0000_1234, '0, 1'b1, 1'b0, 50);
        rd_en0 = 1'b0;

        // Single write on port 1 while port 0 inputs wander.
        rand_inputs();
        wr_en1 = 1'b1;
        addr1  = 32'hDEAD_BEEF;
        run_txn(predict(0, 1), 32'hDEAD_BEEF, write_data1, 1'b0, 1'b0, 20);
        wr_en1 = 1'b0;

        // Round robin with both ports held high.
        rand_inputs();
        rd_en0 = 1'b1;
        wr_en1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p = predict(1, 1);
            run_txn(p, (p == 1) ? addr1 : addr0, write_data1, p == 0, 1'b0, 0);
        end
        rd_en0 = 1'b0;
        wr_en1 = 1'b0;

        // Timeout: controller never answers.
        rand_inputs();
        rd_en0 = 1'b1;
        run_txn(predict(1, 0), addr0, '0, 1'b1, 1'b1, 0);
        rd_en0 = 1'b0;

        // Randomized mix of patterns, ops and occasional timeouts.
        for (int i = 0; i < 24; i++) begin
            rand_inputs();
            n   = $urandom_range(1, 3);
            r0  = n[0];
            r1  = n[1];
            op0 = $urandom_range(0, 2);
            op1 = $urandom_range(0, 2);
            rd_en0 = r0 && op0 != 0;
            wr_en0 = r0 && op0 != 1;
            rd_en1 = r1 && op1 != 0;
            wr_en1 = r1 && op1 != 1;
            p  = predict(r0, r1);
            rd = (p == 1) ? rd_en1 : rd_en0;
            a  = (p == 1) ? addr1 : addr0;
            wd = (p == 1) ? write_data1 : write_data0;
            nb = ($urandom_range(0, 7) == 0);
            run_txn(p, a, wd, rd, nb, 0);
            rd_en0 = 0; wr_en0 = 0; rd_en1 = 0; wr_en1 = 0;
        end

        // Reset during BUSY: enables drop at once, no ack, port 0 wins the next tie.
        rand_inputs();
        rd_en0 = 1'b1;
        run_txn(predict(1, 0), addr0, '0, 1'b1, 1'b0, 0);
        rd_en0 = 1'b0;
        wr_en1 = 1'b1;
        n = 0;
        while (!sd_wr_en && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_grant", sd_wr_en, 1);
        sd_busy = 1'b1;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        check("rst_mid_en", {sd_rd_en, sd_wr_en}, 0);
        check("rst_mid_ack", {ack0, ack1, err0, err1}, 0);
        check("rst_mid_state", state_dbg, 0);
        wr_en1 = 1'b0;
        sd_busy = 1'b0;
        tick();
        reset = 1'b1;
        m_last = 1;
        m_read_data = '0;
        check("rst_mid_rdata", read_data, 0);
        bad = 0;
        repeat (3) begin
            tick();
            if (ack0 || ack1 || sd_rd_en || sd_wr_en) bad++;
        end
        check("rst_mid_quiet", bad, 0);
        rand_inputs();
        rd_en0 = 1'b1;
        wr_en1 = 1'b1;
        p = predict(1, 1);
        run_txn(p, (p == 1) ? addr1 : addr0, write_data1, p == 0, 1'b0, 0);
        rd_en0 = 1'b0;
        wr_en1 = 1'b0;
        repeat (2) tick();

        // ---------------- final report ----------------
        check("protocol", proto_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_arbiter.md
Name: sd_arbiter

Overview:
- Shares one `sd_controller2` block-transfer port between two requesters: port 0 (instruction fetch) and port 1 (data memory).
- Sits between the memory-side requesters and the SD controller, on the controller's fast-clock domain.
- Serialises requests with round-robin priority and drives the controller's hold-until-not-busy enable protocol.
- Returns read blocks and a completion/error pulse to the granted requester.

Parameters:
- DataSize, 4096, block width in bits (one SD sector).
- AddrSize, 32, block address width.
- StartTimeout, 64, cycles allowed between enable assertion and `sd_busy` rising before the transfer is aborted.

Ports:
- clock  in  1  single clock (same clock as the controller's `clock_50M` side).
- reset  in  1  asynchronous, active-low reset.
- rd_en0, wr_en0  in  1 each  port 0 request; held high until ack0.
- addr0  in  AddrSize  port 0 block address.
- write_data0  in  DataSize  port 0 write block.
- ack0  out  1  one-cycle completion pulse for port 0.
- err0  out  1  one-cycle pulse coincident with ack0 when the transfer timed out.
- rd_en1, wr_en1, addr1, write_data1, ack1, err1  -  same as port 0, for port 1.
- read_data  out  DataSize  last completed read block, shared by both ports.
- sd_rd_en, sd_wr_en  out  1 each  controller enables.
- sd_addr  out  AddrSize  controller address.
- sd_write_data  out  DataSize  controller write block.
- sd_read_data  in  DataSize  controller read block.
- sd_busy  in  1  controller busy; high during card initialisation and during transfers.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; sd_rd_en=sd_wr_en=0; sd_addr=0; sd_write_data=0; read_data=0.
  - ack0/1=0; err0/1=0; timeout counter=0.
  - last_grant=1, so port 0 wins the first tie.
  - Enables drop immediately, even mid-transfer. No ack is issued for an aborted transfer.
- Request decode per port:
  - req = rd_en | wr_en.
  - If both rd_en and wr_en are high, the port is treated as a read.
- IDLE:
  - Stays in IDLE while sd_busy=1; this covers initialisation.
  - When sd_busy=0 and any req: grant the only requester, or on a tie grant the port != last_grant.
  - On grant, register addr/write_data/op into sd_addr/sd_write_data and set sd_rd_en or sd_wr_en. Next state ISSUE.
  - Latency: enable is visible 1 cycle after the request is sampled.
- ISSUE:
  - Enable held; counter increments each cycle.
  - sd_busy=1 -> BUSY, counter cleared.
  - Counter reaches StartTimeout-1 with sd_busy still 0 -> ABORT.
- BUSY:
  - Enable, sd_addr and sd_write_data held stable.
  - sd_busy=0 -> DONE.
- DONE (1 cycle):
  - Drop the enable.
  - For a read, read_data <= sd_read_data.
  - Pulse ack of the granted port; last_grant <= granted port.
  - Next state IDLE.
- ABORT (1 cycle):
  - Drop the enable; pulse ack and err of the granted port.
  - read_data unchanged; last_grant updated. Next state IDLE.
- Ack pulse and requester timing:
  - The granted requester must deassert its enable in the cycle after its ack. A still-high enable in IDLE is taken as a new request.
  - The non-granted port's enable and data may change freely during the other port's transfer; they are not sampled until IDLE.
  - Port inputs are sampled only in IDLE. Changes to the granted port's addr/data mid-transfer have no effect.
- Minimum gap between back-to-back transfers: 1 IDLE cycle after DONE/ABORT.
- read_data holds its value until the next successful read completes. Writes and aborts do not alter it.
- Never more than one of sd_rd_en/sd_wr_en high. Never more than one ack high per cycle.

Test Plan:
- Init hold: reset, sd_busy=1 for 200 cycles, rd_en0=1 -> sd_rd_en stays 0. After sd_busy falls, sd_rd_en=1 one cycle later.
- Single read: rd_en0=1, addr0=0x0000_1234; model raises busy 3 cycles after enable, holds it 50 cycles, returns a random block -> sd_addr=0x1234. Then ack0 pulses once with read_data equal to the model block, and sd_rd_en falls in the same cycle.
- Single write: wr_en1=1, addr1=0xDEAD_BEEF, random write_data1 -> sd_wr_en=1 and sd_write_data=write_data1 held through busy. The model's received block equals write_data1; ack1 pulses; read_data unchanged.
- Round-robin: rd_en0 and wr_en1 held high together for 4 transfers -> grant order 0,1,0,1; acks alternate; no overlap of sd enables.
- Timeout: rd_en0=1, model never raises busy -> after 64 cycles in ISSUE, ack0=err0=1 for 1 cycle, sd_rd_en=0, read_data unchanged. A following request is served normally.
- Reset mid-transfer: assert reset during BUSY -> sd_rd_en/sd_wr_en=0 immediately (asynchronous), no ack. After release the arbiter is in IDLE with port 0 winning the next tie.
